// File: rtl/input_event_pkg.sv
// rtl/input_event_pkg.sv - shared constants, event type and slot decoding for the input event arbiter
// Optional feature macro: INPUT_EVENT_RELEASE_EN (release events get their own request slots)
package input_event_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic                is_release;
  } event_t;

  // Map an arbitration slot number to the event it represents.
  function automatic event_t slot_to_event(input int slot);
    event_t e;
`ifdef INPUT_EVENT_RELEASE_EN
    e.id         = MAX_ID_W'(slot >> 1);
    e.is_release = 1'(slot & 1);
`else
    e.id         = MAX_ID_W'(slot);
    e.is_release = 1'b0;
`endif
    return e;
  endfunction

endpackage

// File: rtl/input_debounce_channel.sv
// rtl/input_debounce_channel.sv - two-flop synchronizer, debounce counter and edge detect for one input
// Optional feature macro: INPUT_EVENT_RELEASE_EN (adds the fall_o release strobe)
module input_debounce_channel
  import input_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
`ifdef INPUT_EVENT_RELEASE_EN
  output logic fall_o,
`endif
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The counter only counts while sync differs and is cleared at the threshold, so it can never wrap.
  assign accept  = (sync2 != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign level_o = stable;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_i;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= ~stable;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // One-cycle strobes aligned with the cycle after the stable level changes.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rise_o <= 1'b0;
`ifdef INPUT_EVENT_RELEASE_EN
      fall_o <= 1'b0;
`endif
    end else begin
      rise_o <= accept && !stable;
`ifdef INPUT_EVENT_RELEASE_EN
      fall_o <= accept && stable;
`endif
    end
  end

endmodule

// File: rtl/input_event_arbiter.sv
// rtl/input_event_arbiter.sv - conditions board inputs and serialises press events round-robin onto a valid/ready port
// Optional feature macro: INPUT_EVENT_RELEASE_EN (release events, event_release_o port)
module input_event_arbiter
  import input_event_pkg::*;
#(
  parameter  int NUM_INPUTS      = 4,
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  localparam int ID_W            = $clog2(NUM_INPUTS)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [NUM_INPUTS-1:0] raw_i,
  output logic [NUM_INPUTS-1:0] level_o,
  output logic                  event_valid_o,
  output logic [ID_W-1:0]       event_id_o,
`ifdef INPUT_EVENT_RELEASE_EN
  output logic                  event_release_o,
`endif
  input  logic                  event_ready_i,
  output logic [NUM_INPUTS-1:0] overflow_o,
  input  logic                  clear_overflow_i
);

`ifdef INPUT_EVENT_RELEASE_EN
  localparam int NUM_SLOTS = 2 * NUM_INPUTS;
`else
  localparam int NUM_SLOTS = NUM_INPUTS;
`endif
  localparam int SLOTS_PER_CH = NUM_SLOTS / NUM_INPUTS;
  localparam int SLOT_W       = $clog2(NUM_SLOTS);

  logic [NUM_INPUTS-1:0] rise;
`ifdef INPUT_EVENT_RELEASE_EN
  logic [NUM_INPUTS-1:0] fall;
`endif
  logic [NUM_SLOTS-1:0]  set_req;
  logic [NUM_SLOTS-1:0]  pending;
  logic [NUM_SLOTS-1:0]  pending_next;
  logic [NUM_INPUTS-1:0] ovf_set;
  logic [SLOT_W-1:0]     ptr;
  logic [SLOT_W-1:0]     grant_slot;
  logic                  grant_found;
  logic                  load;
  logic                  take;
  event_t                evt_q;
  logic                  unused_evt;

  for (genvar ch = 0; ch < NUM_INPUTS; ch++) begin : g_ch
    input_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .raw_i   (raw_i[ch]),
      .level_o (level_o[ch]),
`ifdef INPUT_EVENT_RELEASE_EN
      .fall_o  (fall[ch]),
`endif
      .rise_o  (rise[ch])
    );
  end

  // Gather per-channel strobes into arbitration slots (press = even slot when releases are enabled).
  always_comb begin
    set_req = '0;
    for (int ch = 0; ch < NUM_INPUTS; ch++) begin
`ifdef INPUT_EVENT_RELEASE_EN
      set_req[2*ch]   = rise[ch];
      set_req[2*ch+1] = fall[ch];
`else
      set_req[ch]     = rise[ch];
`endif
    end
  end

  // Round-robin search: first pending slot after the last grant, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_slot  = '0;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      idx = (int'(ptr) + i) % NUM_SLOTS;
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_slot  = SLOT_W'(idx);
      end
    end
  end

  assign load = !event_valid_o || event_ready_i;
  assign take = load && grant_found;

  // Pending update: a new strobe beats a same-cycle grant; a strobe onto an untaken pending slot is lost.
  always_comb begin
    pending_next = pending;
    ovf_set      = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (set_req[s] && pending[s] && !(take && grant_slot == SLOT_W'(s))) begin
        ovf_set[s / SLOTS_PER_CH] = 1'b1;
      end
      if (take && grant_slot == SLOT_W'(s)) begin
        pending_next[s] = 1'b0;
      end
      if (set_req[s]) begin
        pending_next[s] = 1'b1;
      end
    end
  end

  // Pending flags, sticky overflow and the output event register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pending       <= '0;
      overflow_o    <= '0;
      event_valid_o <= 1'b0;
      evt_q         <= '0;
      ptr           <= SLOT_W'(NUM_SLOTS - 1);
    end else begin
      pending    <= pending_next;
      overflow_o <= (clear_overflow_i ? '0 : overflow_o) | ovf_set;
      if (load) begin
        if (grant_found) begin
          event_valid_o <= 1'b1;
          evt_q         <= slot_to_event(int'(grant_slot));
          ptr           <= grant_slot;
        end else begin
          event_valid_o <= 1'b0;
        end
      end
    end
  end

  assign event_id_o = evt_q.id[ID_W-1:0];
`ifdef INPUT_EVENT_RELEASE_EN
  assign event_release_o = evt_q.is_release;
`endif
  assign unused_evt = ^evt_q;

endmodule

// File: tb/tb_input_event_arbiter.sv
// tb/tb_input_event_arbiter.sv - directed self-checking bench for input_event_arbiter
module tb_input_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] level;
  logic       valid;
  logic [1:0] id;
  logic       ready;
  logic [3:0] overflow;
  logic       clr;
`ifdef INPUT_EVENT_RELEASE_EN
  logic       release_flag;
`endif

  int checks = 0;
  int passes = 0;
  logic bad;

  input_event_arbiter #(
    .NUM_INPUTS      (4),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .raw_i            (raw),
    .level_o          (level),
    .event_valid_o    (valid),
    .event_id_o       (id),
`ifdef INPUT_EVENT_RELEASE_EN
    .event_release_o  (release_flag),
`endif
    .event_ready_i    (ready),
    .overflow_o       (overflow),
    .clear_overflow_i (clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; raw = 4'b0000; ready = 1'b0; clr = 1'b0;
    tick(3);
    check("reset_level",    32'(level),    32'h0);
    check("reset_valid",    32'(valid),    32'h0);
    check("reset_id",       32'(id),       32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);

    // single press on channel 1: level after 18 cycles, event 2 cycles later for one cycle
    rst = 1'b0; ready = 1'b1; raw = 4'b0010;
    tick(17);
    check("t1_level_early", 32'(level), 32'h0);
    tick(1);
    check("t1_level_rise",  32'(level), 32'h2);
    tick(1);
    check("t1_valid_early", 32'(valid), 32'h0);
    tick(1);
    check("t1_valid",       32'(valid), 32'h1);
    check("t1_id",          32'(id),    32'h1);
    tick(1);
    check("t1_valid_drop",  32'(valid), 32'h0);

    // release of channel 1 makes no event
    raw = 4'b0000; bad = 1'b0;
    repeat (25) begin tick(1); bad |= valid; end
    check("t1_release_noevent", 32'(bad),   32'h0);
    check("t1_release_level",   32'(level), 32'h0);

    // 10-cycle glitch on channel 2 is filtered
    raw = 4'b0100; bad = 1'b0;
    repeat (10) begin tick(1); bad |= (level != 4'b0) | valid; end
    raw = 4'b0000;
    repeat (25) begin tick(1); bad |= (level != 4'b0) | valid; end
    check("t2_glitch", 32'(bad), 32'h0);

    // simultaneous presses 0,2,3 with ready low, pointer fresh from reset
    rst = 1'b1;
    tick(1);
    check("t3_reset_valid", 32'(valid), 32'h0);
    rst = 1'b0; ready = 1'b0; raw = 4'b1101;
    tick(20);
    check("t3_first_valid", 32'(valid), 32'h1);
    check("t3_first_id",    32'(id),    32'h0);
    bad = 1'b0;
    repeat (20) begin tick(1); bad |= !(valid === 1'b1 && id === 2'd0); end
    check("t3_frozen", 32'(bad), 32'h0);
    ready = 1'b1;
    tick(1);
    check("t3_second_id", 32'({valid, id}), 32'h6);
    tick(1);
    check("t3_third_id",  32'({valid, id}), 32'h7);
    tick(1);
    check("t3_drain",     32'(valid),       32'h0);

    // double press on channel 1 while channel 0 occupies the output
    raw = 4'b0000; ready = 1'b0;
    tick(20);
    check("t4_idle", 32'(valid), 32'h0);
    raw = 4'b0001;
    tick(20);
    check("t4_hold0", 32'({valid, id}), 32'h4);
    raw = 4'b0011;
    tick(20);
    raw = 4'b0001;
    tick(20);
    check("t4_no_ovf_yet", 32'(overflow), 32'h0);
    raw = 4'b0011;
    tick(20);
    check("t4_overflow",  32'(overflow),    32'h2);
    check("t4_still0",    32'({valid, id}), 32'h4);
    ready = 1'b1;
    tick(1);
    check("t4_id1",       32'({valid, id}), 32'h5);
    tick(1);
    check("t4_single",    32'(valid),       32'h0);
    check("t4_sticky",    32'(overflow),    32'h2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t4_cleared",   32'(overflow),    32'h0);

    // channels 0 and 1 pressed together repeatedly alternate
    raw = 4'b0000;
    tick(20);
    for (int r = 0; r < 2; r++) begin
      raw = 4'b0011;
      tick(20);
      check("t5_grant0", 32'({valid, id}), 32'h4);
      tick(1);
      check("t5_grant1", 32'({valid, id}), 32'h5);
      tick(1);
      check("t5_empty",  32'(valid),       32'h0);
      raw = 4'b0000;
      tick(20);
    end

    // reset while an event is presented and another is pending
    ready = 1'b0; raw = 4'b0011;
    tick(20);
    check("t6_presented", 32'({valid, id}), 32'h4);
    rst = 1'b1; raw = 4'b0001;
    tick(1);
    check("t6_rst_valid", 32'(valid),    32'h0);
    check("t6_rst_id",    32'(id),       32'h0);
    check("t6_rst_level", 32'(level),    32'h0);
    check("t6_rst_ovf",   32'(overflow), 32'h0);
    rst = 1'b0; ready = 1'b1;
    tick(19);
    check("t6_not_yet",   32'(valid),       32'h0);
    tick(1);
    check("t6_repress",   32'({valid, id}), 32'h4);
    tick(1);
    check("t6_discarded", 32'(valid),       32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
